pipelined_rca_adder: RTL and testbench

//   Parametrised, pipelined ripple-carry adder: WIDTH-bit a + b + cin -> sum, cout.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_seg_cell.sv | 25 ++
 rtl/pipelined_rca_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_rca_adder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, stage control record and depth helper for the pipelined ripple-carry adder
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 16;
    localparam int ADDER_DEFAULT_SEG   = 4;

    // Control half of a pipeline stage record; the data half (partial sum,
    // remaining operands) is width-dependent and is wrapped around this in the top.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int stage_count(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg_cell.sv
// rtl/adder_seg_cell.sv - combinational SEG-bit ripple segment built from 1-bit full-adder slices
module adder_seg_cell
    import adder_pkg::*;
#(
    parameter int SEG = ADDER_DEFAULT_SEG
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c[i]);
    end

    assign co = c[SEG];

endmodule

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - pipelined ripple-carry adder, one SEG-bit segment per stage; signed overflow flag under OVERFLOW_FLAG_EN
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH,
    parameter int SEG   = ADDER_DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stage_count(WIDTH, SEG);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];

    logic [STAGES-1:0][WIDTH-1:0] a_in;
    logic [STAGES-1:0][WIDTH-1:0] b_in;
    logic [STAGES-1:0][WIDTH-1:0] sum_in;
    logic [STAGES-1:0]            c_in;
    logic [STAGES-1:0]            v_in;
    logic [STAGES-1:0][SEG-1:0]   seg_s;
    logic [STAGES-1:0]            seg_co;
    logic [STAGES:0]              ld;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = a;
            assign b_in[k]   = b;
            assign c_in[k]   = cin;
            assign v_in[k]   = in_valid;
            assign sum_in[k] = '0;
        end else begin : g_body
            assign a_in[k]   = st_q[k-1].a;
            assign b_in[k]   = st_q[k-1].b;
            assign c_in[k]   = st_q[k-1].ctl.carry;
            assign v_in[k]   = st_q[k-1].ctl.valid;
            assign sum_in[k] = st_q[k-1].sum;
        end

        adder_seg_cell #(
            .SEG(SEG)
        ) u_cell (
            .x (a_in[k][SEG*k +: SEG]),
            .y (b_in[k][SEG*k +: SEG]),
            .ci(c_in[k]),
            .s (seg_s[k]),
            .co(seg_co[k])
        );
    end

    // Backward load chain: a stage may load when empty or when its successor
    // is loading, so bubbles collapse while the output is stalled.
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !st_q[k].ctl.valid || ld[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = st_q[k];
            if (ld[k]) begin
                st_d[k].ctl.valid          = v_in[k];
                st_d[k].ctl.carry          = seg_co[k];
                st_d[k].sum                = sum_in[k];
                st_d[k].sum[SEG*k +: SEG]  = seg_s[k];
                st_d[k].a                  = a_in[k];
                st_d[k].b                  = b_in[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is recovered as a ^ b ^ s at that bit.
    always_comb begin
        ovf_d = ovf_q;
        if (ld[STAGES-1]) begin
            ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                  ^ seg_s[STAGES-1][SEG-1] ^ seg_co[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = ld[0];
    assign out_valid = st_q[STAGES-1].ctl.valid;
    assign sum       = st_q[STAGES-1].sum;
    assign cout      = st_q[STAGES-1].ctl.carry;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb/tb_pipelined_rca_adder.sv - self-checking bench for pipelined_rca_adder against an arithmetic reference queue
module tb_pipelined_rca_adder;

    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;
`ifdef OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks    = 0;
    int failures  = 0;
    int outs_seen = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t model_q[$];

    logic [WIDTH-1:0] tv_a   [8] = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h7FFF,
                                     16'h8000, 16'h1357, 16'hF0F0, 16'h00FF};
    logic [WIDTH-1:0] tv_b   [8] = '{16'h5A5A, 16'hFFFF, 16'hFFFF, 16'h0001,
                                     16'h8000, 16'h2468, 16'h0F0F, 16'hFF00};
    logic             tv_c   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] tv_sum [8] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h8000,
                                     16'h0001, 16'h37BF, 16'h0000, 16'hFFFF};
    logic             tv_co  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    pipelined_rca_adder #(
        .WIDTH(WIDTH),
        .SEG  (SEG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        exp_t           e;
        logic [WIDTH:0] t;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = OVF_EN && (x[WIDTH-1] == y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference scoreboard: every accepted input is pushed, every drained output popped.
    logic             held_v = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_ovf;

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, held_sum);
                check("hold_cout", cout, held_cout);
                check("hold_ovf", ovf, held_ovf);
            end
            held_v    = out_valid && !out_ready;
            held_sum  = sum;
            held_cout = cout;
            held_ovf  = ovf;
            if (out_valid) begin
                if (model_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else if (out_ready) begin : pop
                    exp_t e;
                    e = model_q.pop_front();
                    check("sb_sum", sum, e.sum);
                    check("sb_cout", cout, e.cout);
                    check("sb_ovf", ovf, e.ovf);
                    outs_seen++;
                end
            end
            if (in_valid && in_ready) begin
                model_q.push_back(model(a, b, cin));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        int n = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [WIDTH-1:0] s, input logic c,
                              input logic o);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"}, sum, s);
        check({name, "_cout"}, cout, c);
        check({name, "_ovf"}, ovf, o);
        tick();
    endtask

    initial begin
        int lat;
        int acc;
        int n;
        int base;
        int v_seen;
        logic [WIDTH-1:0] snap;
        exp_t pin;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        for (int i = 0; i < 8; i++) begin
            pin = model(tv_a[i], tv_b[i], tv_c[i]);
            check("model_pin_sum", pin.sum, tv_sum[i]);
            check("model_pin_cout", pin.cout, tv_co[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);
        tick();

        // Single item latency with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h4321;
        cin       = 1'b0;
        lat       = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end while (!out_valid && lat < 30);
        check("t1_latency", lat, STAGES);
        check("t1_sum", sum, 16'h5555);
        check("t1_cout", cout, 0);
        tick();

        send(16'hFFFF, 16'h0000, 1'b1);
        expect_out("t2_ripple", 16'h0000, 1'b1, 1'b0);

        send(16'h8000, 16'h8000, 1'b0);
        expect_out("t2_wrap", 16'h0000, 1'b1, OVF_EN);

        send(16'h7FFF, 16'h0001, 1'b0);
        expect_out("t6_pos_ovf", 16'h8000, 1'b0, OVF_EN);

        send(16'h8000, 16'hFFFF, 1'b0);
        expect_out("t6_neg_ovf", 16'h7FFF, 1'b1, OVF_EN);

        // Back-to-back stream; drain must complete STAGES cycles after the last accept.
        base = outs_seen;
        for (int i = 0; i < 8; i++) begin
            send(tv_a[i], tv_b[i], tv_c[i]);
        end
        n = 0;
        while (outs_seen < base + 8 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t3_drain_cycles", n, STAGES);
        check("t3_count", outs_seen - base, 8);
        tick();

        // Fill under back-pressure.
        out_ready = 1'b0;
        acc       = 0;
        for (int i = 0; i < 8; i++) begin
            a        = 16'(acc * 16'h2345 + 16'h0F0F);
            b        = 16'(acc * 16'h1111);
            cin      = acc[0];
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_accepts", acc, STAGES);
        check("t4_in_ready_full", in_ready, 0);
        check("t4_head_valid", out_valid, 1);
        check("t4_head_sum", sum, 16'h0F0F);
        snap = sum;
        repeat (3) @(negedge clk);
        check("t4_stall_sum", sum, snap);
        tick();

        // Full pipe: accept and drain in the same cycle.
        out_ready = 1'b1;
        a         = 16'h0101;
        b         = 16'h1010;
        cin       = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("t4_full_passthrough_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (model_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t4_drained", model_q.size(), 0);
        tick();

        // Reset with items in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        send(16'h5555, 16'h6666, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_sum", sum, 0);
        check("t5_cout", cout, 0);
        check("t5_ovf", ovf, 0);
        check("t5_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        v_seen    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) v_seen++;
        end
        check("t5_no_stale", v_seen, 0);
        tick();

        check("final_queue_empty", model_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
